// File: rtl/pkg_predictor.sv
// Shared types and helpers for the bimodal predictor: saturating counter step,
// counter reset value and the flush-mode selector.
package pkg_predictor;

  localparam int unsigned CTR_MAX_WIDTH = 16;

  typedef enum logic {
    FLUSH_LEGACY = 1'b0,
    FLUSH_FULL   = 1'b1
  } flush_mode_e;

  function automatic logic [CTR_MAX_WIDTH-1:0] ctr_reset_value(input int unsigned width);
    logic [CTR_MAX_WIDTH-1:0] all_ones;
    all_ones = {CTR_MAX_WIDTH{1'b1}} >> (CTR_MAX_WIDTH - width);
    return all_ones >> 1;
  endfunction

  // Weakly-not-taken for the common 2-bit configuration.
  localparam logic [1:0] CTR_RESET_2B = 2'b01;

  function automatic logic [CTR_MAX_WIDTH-1:0] sat_update(
    input logic [CTR_MAX_WIDTH-1:0] ctr,
    input logic                     taken,
    input int unsigned              width
  );
    logic [CTR_MAX_WIDTH-1:0] max_v;
    logic [CTR_MAX_WIDTH-1:0] res;
    max_v = {CTR_MAX_WIDTH{1'b1}} >> (CTR_MAX_WIDTH - width);
    if (taken) begin
      if (ctr >= max_v) begin
        res = max_v;
      end else begin
        res = ctr + CTR_MAX_WIDTH'(1);
      end
    end else begin
      if (ctr == {CTR_MAX_WIDTH{1'b0}}) begin
        res = {CTR_MAX_WIDTH{1'b0}};
      end else begin
        res = ctr - CTR_MAX_WIDTH'(1);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// Reusable up-counter that sticks at all-ones; synchronous active-low reset.
module contador_saturado
  import pkg_predictor::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: step only while below saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/predictor_bimodal_flush.sv
// Bimodal branch predictor: table of saturating counters looked up by IF PC,
// trained by EX resolution, with same-cycle flush generation and perf counters.
module predictor_bimodal_flush
  import pkg_predictor::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned FLUSH_MODE = 0,
  parameter int unsigned PERF_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [PC_WIDTH-1:0]   pc_if_i,
  output logic [CTR_WIDTH-1:0]  prediccion_o,
  output logic                  taken_pred_o,
  input  logic                  resolve_valid_i,
  input  logic [PC_WIDTH-1:0]   pc_ex_i,
  input  logic [CTR_WIDTH-1:0]  prediccion_ex_i,
  input  logic                  taken_i,
  output logic                  flush_predictor_o,
  output logic [PERF_WIDTH-1:0] cnt_saltos_o,
  output logic [PERF_WIDTH-1:0] cnt_fallos_o
);

  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
  localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'(ctr_reset_value(CTR_WIDTH));

  logic [CTR_WIDTH-1:0]  tabla_q [ENTRIES];
  logic [INDEX_BITS-1:0] idx_if_s;
  logic [INDEX_BITS-1:0] idx_ex_s;
  logic [CTR_WIDTH-1:0]  entry_d;
  logic                  pred_taken_ex_s;
  logic                  flush_s;

  assign idx_if_s        = pc_if_i[INDEX_BITS+1:2];
  assign idx_ex_s        = pc_ex_i[INDEX_BITS+1:2];
  assign pred_taken_ex_s = prediccion_ex_i[CTR_WIDTH-1];
  assign entry_d         = CTR_WIDTH'(sat_update(CTR_MAX_WIDTH'(tabla_q[idx_ex_s]), taken_i, CTR_WIDTH));

  // Lookup with bypass of the update landing on the same entry this cycle.
  always_comb begin
    if (rst_n_i && resolve_valid_i && (idx_ex_s == idx_if_s)) begin
      prediccion_o = entry_d;
    end else begin
      prediccion_o = tabla_q[idx_if_s];
    end
  end

  assign taken_pred_o = prediccion_o[CTR_WIDTH-1];

  // Flush decision is made from the prediction carried with the branch.
  always_comb begin
    flush_s = 1'b0;
    if (!rst_n_i || !resolve_valid_i) begin
      flush_s = 1'b0;
    end else if (FLUSH_MODE == int'(FLUSH_FULL)) begin
      flush_s = pred_taken_ex_s ^ taken_i;
    end else begin
      flush_s = pred_taken_ex_s & ~taken_i;
    end
  end

  assign flush_predictor_o = flush_s;

  // Counter table: reset to weakly-not-taken, one training write per cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tabla_q[i] <= CTR_RESET;
      end
    end else if (resolve_valid_i) begin
      tabla_q[idx_ex_s] <= entry_d;
    end
  end

  contador_saturado #(
    .WIDTH (PERF_WIDTH)
  ) u_cnt_saltos (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (resolve_valid_i),
    .cnt_o   (cnt_saltos_o)
  );

  contador_saturado #(
    .WIDTH (PERF_WIDTH)
  ) u_cnt_fallos (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (flush_s),
    .cnt_o   (cnt_fallos_o)
  );

endmodule

// File: tb/tb_predictor_bimodal_flush.sv
// Bench for predictor_bimodal_flush: legacy and full flush instances driven in
// parallel, checked each cycle against a behavioural model plus literal values.
module tb_predictor_bimodal_flush;

  localparam int CMAX   = 3;
  localparam int RSTV   = 1;
  localparam int NENT   = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        rv;
  logic [31:0] pc_ex;
  logic [1:0]  pex;
  logic        tk;

  logic [1:0]  pred0, pred1;
  logic        tp0, tp1, fl0, fl1;
  logic [31:0] s0, s1, f0, f1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int unsigned m_tbl [NENT];
  int unsigned m_saltos, m_fallos0, m_fallos1;

  always #5 clk = ~clk;

  predictor_bimodal_flush #(
    .PC_WIDTH(32), .INDEX_BITS(6), .CTR_WIDTH(2), .FLUSH_MODE(0), .PERF_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pc_if_i(pc_if), .prediccion_o(pred0),
    .taken_pred_o(tp0), .resolve_valid_i(rv), .pc_ex_i(pc_ex),
    .prediccion_ex_i(pex), .taken_i(tk), .flush_predictor_o(fl0),
    .cnt_saltos_o(s0), .cnt_fallos_o(f0)
  );

  predictor_bimodal_flush #(
    .PC_WIDTH(32), .INDEX_BITS(6), .CTR_WIDTH(2), .FLUSH_MODE(1), .PERF_WIDTH(32)
  ) dut_full (
    .clk_i(clk), .rst_n_i(rst_n), .pc_if_i(pc_if), .prediccion_o(pred1),
    .taken_pred_o(tp1), .resolve_valid_i(rv), .pc_ex_i(pc_ex),
    .prediccion_ex_i(pex), .taken_i(tk), .flush_predictor_o(fl1),
    .cnt_saltos_o(s1), .cnt_fallos_o(f1)
  );

  function automatic int unsigned idx(input logic [31:0] pc);
    return (pc / 4) % NENT;
  endfunction

  function automatic int unsigned nxt(input int unsigned v, input bit t);
    if (t) return (v >= CMAX) ? CMAX : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  function automatic bit exp_flush(input bit full);
    bit pt;
    if (!rst_n || !rv) return 1'b0;
    pt = (pex >= 2);
    if (full) return pt != tk;
    return pt && !tk;
  endfunction

  function automatic int unsigned exp_pred();
    if (rst_n && rv && idx(pc_ex) == idx(pc_if)) return nxt(m_tbl[idx(pc_ex)], tk);
    return m_tbl[idx(pc_if)];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model state advance at each clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) m_tbl[i] <= RSTV;
      m_saltos  <= 0;
      m_fallos0 <= 0;
      m_fallos1 <= 0;
    end else if (rv) begin
      m_tbl[idx(pc_ex)] <= nxt(m_tbl[idx(pc_ex)], tk);
      m_saltos  <= m_saltos + 1;
      m_fallos0 <= m_fallos0 + (exp_flush(1'b0) ? 1 : 0);
      m_fallos1 <= m_fallos1 + (exp_flush(1'b1) ? 1 : 0);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pred0",  {30'd0, pred0}, exp_pred());
      chk("m_pred1",  {30'd0, pred1}, exp_pred());
      chk("m_tp0",    {31'd0, tp0},   (exp_pred() >= 2) ? 1 : 0);
      chk("m_tp1",    {31'd0, tp1},   (exp_pred() >= 2) ? 1 : 0);
      chk("m_flush0", {31'd0, fl0},   {31'd0, exp_flush(1'b0)});
      chk("m_flush1", {31'd0, fl1},   {31'd0, exp_flush(1'b1)});
      chk("m_saltos0", s0, m_saltos);
      chk("m_saltos1", s1, m_saltos);
      chk("m_fallos0", f0, m_fallos0);
      chk("m_fallos1", f1, m_fallos1);
    end
  end

  task automatic step(input bit r, input bit v, input logic [31:0] pe,
                      input logic [1:0] px, input bit t, input logic [31:0] pi);
    @(posedge clk);
    #1;
    rst_n = r; rv = v; pc_ex = pe; pex = px; tk = t; pc_if = pi;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] sat_exp [8];
    sat_exp = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    rst_n = 1'b0; rv = 1'b0; pc_ex = 32'h0; pex = 2'b00; tk = 1'b0; pc_if = 32'h40;
    @(posedge clk);
    #1 chk_en = 1'b1;
    step(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h40);
    chk("rst_pred", {30'd0, pred0}, 32'h1);
    chk("rst_tp", {31'd0, tp0}, 32'h0);
    chk("rst_saltos", s0, 32'h0);
    chk("rst_fallos", f0, 32'h0);

    // Predicted taken, actually not taken: both modes flush.
    step(1'b1, 1'b1, 32'h40, 2'b11, 1'b0, 32'h0);
    chk("legacy_flush_tnt", {31'd0, fl0}, 32'h1);
    chk("full_flush_tnt", {31'd0, fl1}, 32'h1);
    // Predicted not taken, actually taken: only full mode flushes.
    step(1'b1, 1'b1, 32'h40, 2'b01, 1'b1, 32'h0);
    chk("fallos_after1", f0, 32'h1);
    chk("legacy_noflush_ntt", {31'd0, fl0}, 32'h0);
    chk("full_flush_ntt", {31'd0, fl1}, 32'h1);
    // Entry 0x40 is back at 01; forward its taken update, predicted 10.
    step(1'b1, 1'b1, 32'h40, 2'b10, 1'b1, 32'h40);
    chk("fwd_pred", {30'd0, pred0}, 32'h2);
    chk("full_noflush_tt", {31'd0, fl1}, 32'h0);
    step(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'h140);
    chk("alias_pred", {30'd0, pred0}, 32'h2);
    chk("saltos_3", s0, 32'h3);
    chk("fallos_legacy_1", f0, 32'h1);
    chk("fallos_full_2", f1, 32'h2);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 32'h80, 2'b01, (i < 4), 32'h80);
      chk("sat_seq", {30'd0, pred0}, {30'd0, sat_exp[i]});
    end
    step(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'h82);
    chk("sat_floor", {30'd0, pred0}, 32'h0);

    // Train 0xC0 to strongly taken, then reset with an update pending.
    step(1'b1, 1'b1, 32'hC0, 2'b01, 1'b1, 32'h0);
    step(1'b1, 1'b1, 32'hC0, 2'b10, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'hC0);
    chk("trained_pred", {30'd0, pred0}, 32'h3);
    step(1'b0, 1'b1, 32'hC0, 2'b11, 1'b0, 32'hC0);
    chk("rst_flush_low0", {31'd0, fl0}, 32'h0);
    chk("rst_flush_low1", {31'd0, fl1}, 32'h0);
    step(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'hC0);
    chk("midrst_pred", {30'd0, pred0}, 32'h1);
    chk("midrst_saltos", s0, 32'h0);
    chk("midrst_fallos", f1, 32'h0);
    step(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'h40);
    chk("midrst_pred40", {30'd0, pred1}, 32'h1);

    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/predictor_bimodal_flush.md
Name: predictor_bimodal_flush

Overview:
- Parametrised successor to the 2-bit flush controller: a bimodal branch predictor table of N-bit saturating counters, plus mispredict/flush generation at branch resolution.
- Lookup is indexed by the IF-stage PC. Update and flush are driven by the EX-stage resolution.
- Flush generation is selectable: legacy mode flushes only on predicted-taken/actual-not-taken; full mode flushes on any direction mismatch.
- Includes saturating performance counters for resolved branches and mispredicts.

Parameters:
- PC_WIDTH, 32, PC width in bits.
- INDEX_BITS, 6, table index width; ENTRIES = 2**INDEX_BITS (derived localparam).
- CTR_WIDTH, 2, saturating counter width (>=2).
- FLUSH_MODE, 0, 0 = flush only when predicted taken and actual not taken; 1 = flush on any direction mismatch.
- PERF_WIDTH, 32, performance counter width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  synchronous reset, active-low.
- pc_if_i  in  PC_WIDTH  IF-stage PC for lookup.
- prediccion_o  out  CTR_WIDTH  counter value for pc_if_i; carried down the pipeline.
- taken_pred_o  out  1  MSB of prediccion_o.
- resolve_valid_i  in  1  a branch resolves in EX this cycle.
- pc_ex_i  in  PC_WIDTH  PC of the resolving branch.
- prediccion_ex_i  in  CTR_WIDTH  counter value the branch was predicted with.
- taken_i  in  1  actual branch outcome.
- flush_predictor_o  out  1  flush request to IF/ID.
- cnt_saltos_o  out  PERF_WIDTH  number of resolved branches.
- cnt_fallos_o  out  PERF_WIDTH  number of flushes raised.

Behaviour:
- Index = pc[INDEX_BITS+1:2]; PC bits [1:0] are ignored.
- Reset (rst_n_i=0 at a clock edge):
  - every table entry is set to weakly-not-taken, 2**(CTR_WIDTH-1)-1 (2'b01 for CTR_WIDTH=2);
  - both perf counters are set to 0.
  - Reset mid-operation discards any update presented in that cycle.
- Outputs while held in reset:
  - prediccion_o reflects the reset value of the entry after the first reset edge;
  - flush_predictor_o is 0, forced low while rst_n_i=0.
- Lookup:
  - combinational read, zero latency;
  - prediccion_o = table[idx(pc_if_i)].
- Forwarding: if resolve_valid_i=1 and idx(pc_ex_i)==idx(pc_if_i) in the same cycle, prediccion_o returns the post-update value.
- Flush:
  - combinational, same cycle as resolution, gated by resolve_valid_i;
  - pred_taken = prediccion_ex_i[CTR_WIDTH-1];
  - FLUSH_MODE=0: flush = pred_taken & ~taken_i;
  - FLUSH_MODE=1: flush = pred_taken ^ taken_i.
  - The flush decision uses prediccion_ex_i, never the current table value; later aliasing updates do not change it.
- Update: on a clock edge with resolve_valid_i=1, entry idx(pc_ex_i) is updated:
  - from its current table value, not from prediccion_ex_i;
  - +1 if taken_i, -1 otherwise;
  - saturating at all-ones and at 0, with no wrap.
- Only one update per cycle.
- Perf counters:
  - cnt_saltos_o increments on each resolve_valid_i edge;
  - cnt_fallos_o increments when flush_predictor_o=1;
  - both saturate at all-ones.
- The block has no internal FSM beyond the counters. Outputs change only on clk_i edges or combinationally from inputs.

Decomposition:
- Package pkg_predictor:
  - function sat_update(ctr, taken), returning the saturated next counter value;
  - the localparam for the reset value;
  - the flush-mode enum (FLUSH_LEGACY=0, FLUSH_FULL=1).
- Sub-module contador_saturado: one reusable saturating counter, used for the perf counters.
- The table is a flop array inside the top module.

Test Plan:
- Reset, then lookup pc_if_i=0x40 -> prediccion_o=2'b01, taken_pred_o=0; cnt_saltos_o=0 and cnt_fallos_o=0.
- Legacy mode: resolve 0x40 with prediccion_ex_i=2'b11, taken_i=0 -> flush_predictor_o=1 in the same cycle, cnt_fallos_o=1. With prediccion_ex_i=2'b01, taken_i=1 -> flush_predictor_o=0.
- FLUSH_MODE=1: prediccion_ex_i=2'b01, taken_i=1 -> flush_predictor_o=1. With prediccion_ex_i=2'b10, taken_i=1 -> flush_predictor_o=0.
- Saturation: resolve 0x80 as taken 4 times -> entry sequence 01→10→11→11. Then not-taken 4 times -> 10→01→00→00.
- Forwarding: entry=2'b01; resolve pc_ex_i=0x40 taken while pc_if_i=0x40 -> prediccion_o=2'b10 in the same cycle. Alias check: pc 0x140 with INDEX_BITS=6 maps to the same entry.
- Mid-run reset: after the table is trained to 2'b11, assert rst_n_i for 1 cycle while resolve_valid_i=1 -> entry=2'b01, counters=0, and the update is dropped.
